// File: rtl/vram_cpu_writer.sv
// CPU-side VRAM writer: snoops 68000 framebuffer writes, queues them as byte writes
// and plays them into VRAM during pixel slots 0..5, leaving slot 7 to the video fetch.
module vram_cpu_writer #(
  parameter logic [23:0] FB_BASE  = 24'h3FA700,
  parameter int          VRAM_AW  = 13,
  parameter int          FIFO_DEP = 4
) (
  input  logic               pixClock,
  input  logic               nReset,
  input  logic [2:0]         hCount,
  input  logic [22:0]        cpuAddr,
  input  logic [15:0]        cpuData,
  input  logic               nAS,
  input  logic               nUDS,
  input  logic               nLDS,
  input  logic               cpuRnW,
  output logic [VRAM_AW-1:0] vramAddr,
  output logic [7:0]         vramDataOut,
  output logic               vramDataOE,
  output logic               nvramWE,
  output logic               wrBusy,
  output logic               ovfErr,
  output logic [1:0]         dbgState
);

  localparam int PW = $clog2(FIFO_DEP);
  localparam int EW = VRAM_AW + 8;
  localparam logic [PW:0] L_DEP = (PW+1)'(FIFO_DEP);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  logic r_as_m, r_as_s, r_uds_m, r_uds_s, r_lds_m, r_lds_s, r_rnw_m, r_rnw_s;
  logic r_armed, r_cap_vld, r_cap_uds, r_cap_lds;
  logic [22:0] r_cap_addr;
  logic [15:0] r_cap_data;
  logic [EW-1:0] r_mem [FIFO_DEP];
  logic [PW:0] r_wptr, r_rptr;
  logic r_ovf;
  state_t r_state;
  logic [VRAM_AW-1:0] r_vaddr;
  logic [7:0] r_vdata;
  logic r_oe, r_nwe;

  always_ff @(posedge pixClock or negedge nReset) begin
    if (!nReset) begin
      {r_as_m, r_as_s, r_uds_m, r_uds_s} <= 4'b1111;
      {r_lds_m, r_lds_s, r_rnw_m, r_rnw_s} <= 4'b1111;
    end else begin
      r_as_m <= nAS;    r_as_s <= r_as_m;
      r_uds_m <= nUDS;  r_uds_s <= r_uds_m;
      r_lds_m <= nLDS;  r_lds_s <= r_lds_m;
      r_rnw_m <= cpuRnW; r_rnw_s <= r_rnw_m;
    end
  end

  // One capture per bus cycle: armed clears on capture and re-arms once nAS is seen high.
  logic w_cap;
  assign w_cap = !r_as_s && !r_rnw_s && (!r_uds_s || !r_lds_s) && r_armed;

  always_ff @(posedge pixClock or negedge nReset) begin
    if (!nReset) begin
      r_armed    <= 1'b1;
      r_cap_vld  <= 1'b0;
      r_cap_uds  <= 1'b0;
      r_cap_lds  <= 1'b0;
      r_cap_addr <= '0;
      r_cap_data <= '0;
    end else begin
      r_cap_vld <= w_cap;
      if (w_cap) begin
        r_armed    <= 1'b0;
        r_cap_addr <= cpuAddr;
        r_cap_data <= cpuData;
        r_cap_uds  <= !r_uds_s;
        r_cap_lds  <= !r_lds_s;
      end else if (r_as_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  logic [23:0] w_off;
  logic w_in_win, w_empty, w_fits, w_try_push, w_push, w_drop, w_pop;
  logic [1:0] w_need;
  logic [PW:0] w_count, w_free;
  logic [PW-1:0] w_widx0, w_widx1;
  logic [EW-1:0] w_ent_u, w_ent_l, w_head;

  assign w_off      = {r_cap_addr, 1'b0} - FB_BASE;
  assign w_in_win   = (w_off[23:VRAM_AW] == '0);
  assign w_need     = {1'b0, r_cap_uds} + {1'b0, r_cap_lds};
  assign w_count    = r_wptr - r_rptr;
  assign w_free     = L_DEP - w_count;
  assign w_empty    = (r_wptr == r_rptr);
  assign w_fits     = ((PW+1)'(w_need) <= w_free);
  assign w_try_push = r_cap_vld && w_in_win;
  // Push side: a whole bus cycle enters only if all its bytes fit (else dropped, ovf flagged).
  // Pop side: the FSM takes the head only in IDLE with the FIFO non-empty and a slot <= 3.
  assign w_push     = w_try_push && w_fits;
  assign w_drop     = w_try_push && !w_fits;
  assign w_pop      = (r_state == S_IDLE) && !w_empty && (hCount <= 3'd3);
  assign w_widx0    = r_wptr[PW-1:0];
  assign w_widx1    = w_widx0 + PW'(1);
  assign w_ent_u    = {w_off[VRAM_AW-1:0], r_cap_data[15:8]};
  assign w_ent_l    = {w_off[VRAM_AW-1:0] | VRAM_AW'(1), r_cap_data[7:0]};
  assign w_head     = r_mem[r_rptr[PW-1:0]];

  always_ff @(posedge pixClock) begin
    if (w_push) begin
      if (r_cap_uds) begin
        r_mem[w_widx0] <= w_ent_u;
        if (r_cap_lds) r_mem[w_widx1] <= w_ent_l;
      end else begin
        r_mem[w_widx0] <= w_ent_l;
      end
    end
  end

  always_ff @(posedge pixClock or negedge nReset) begin
    if (!nReset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (PW+1)'(w_need);
      if (w_pop)  r_rptr <= r_rptr + (PW+1)'(1);
      if (w_drop) r_ovf  <= 1'b1;
    end
  end

  // A pass starting at slot <= 3 strobes by slot 5 and releases the bus by slot 6.
  always_ff @(posedge pixClock or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;
      r_vaddr <= '0;
      r_vdata <= '0;
      r_oe    <= 1'b0;
      r_nwe   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_vaddr <= w_head[EW-1:8];
            r_vdata <= w_head[7:0];
            r_oe    <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_nwe   <= 1'b0;
          r_state <= S_STROBE;
        end
        S_STROBE: begin
          r_nwe   <= 1'b1;
          r_state <= S_HOLD;
        end
        default: begin
          r_oe    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign vramAddr    = r_vaddr;
  assign vramDataOut = r_vdata;
  assign vramDataOE  = r_oe;
  assign nvramWE     = r_nwe;
  assign ovfErr      = r_ovf;
  assign wrBusy      = !w_empty || (r_state != S_IDLE);
  assign dbgState    = r_state;

endmodule

// File: tb/tb_vram_cpu_writer.sv
// Bench for vram_cpu_writer: randomized 68000 write cycles against a byte-write
// queue model, plus directed window, overflow, slot-hold and reset cases.
module tb_vram_cpu_writer;

  localparam logic [23:0] FB_BASE = 24'h3FA700;
  localparam int AW  = 13;
  localparam int DEP = 4;

  logic pixClock, nReset;
  logic [2:0] hCount;
  logic [22:0] cpuAddr;
  logic [15:0] cpuData;
  logic nAS, nUDS, nLDS, cpuRnW;
  logic [AW-1:0] vramAddr;
  logic [7:0] vramDataOut;
  logic vramDataOE, nvramWE, wrBusy, ovfErr;
  logic [1:0] dbgState;

  vram_cpu_writer #(.FB_BASE(FB_BASE), .VRAM_AW(AW), .FIFO_DEP(DEP)) dut (
    .pixClock(pixClock), .nReset(nReset), .hCount(hCount),
    .cpuAddr(cpuAddr), .cpuData(cpuData), .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS),
    .cpuRnW(cpuRnW), .vramAddr(vramAddr), .vramDataOut(vramDataOut),
    .vramDataOE(vramDataOE), .nvramWE(nvramWE), .wrBusy(wrBusy), .ovfErr(ovfErr),
    .dbgState(dbgState)
  );

  logic [AW+7:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_writes = 0;
  int model_room = -1;
  bit exp_ovf = 0;
  bit hold = 0;
  logic [2:0] hold_val = 3'd0;
  bit prev_low = 0;

  // clock/reset block
  initial begin
    pixClock = 1'b0;
    forever #5 pixClock = ~pixClock;
  end

  initial begin
    hCount = 3'd0;
    forever begin
      @(posedge pixClock);
      #1;
      if (hold) hCount = hold_val;
      else hCount = hCount + 3'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every VRAM strobe must match the oldest expected byte write.
  initial begin
    logic [AW+7:0] e;
    forever begin
      @(negedge pixClock);
      if (nReset && nvramWE === 1'b0) begin
        n_writes++;
        check("we_slot", 32'(hCount <= 3'd5), 32'd1);
        check("we_oe", 32'(vramDataOE), 32'd1);
        check("we_pulse", 32'(prev_low), 32'd0);
        check("we_expected_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("we_addr", 32'(vramAddr), 32'(e[AW+7:8]));
          check("we_data", 32'(vramDataOut), 32'(e[7:0]));
        end
      end
      prev_low = (nvramWE === 1'b0);
    end
  end

  // Reference model: a bus cycle becomes 0, 1 or 2 byte writes, UDS byte first.
  task automatic model_write(input logic [23:0] baddr, input logic [15:0] d,
                             input bit uds, input bit lds, input bit rd);
    int off, need;
    logic [AW-1:0] a;
    off  = int'(baddr) - int'(FB_BASE);
    need = int'(uds) + int'(lds);
    if (rd || need == 0 || off < 0 || off >= (1 << AW)) return;
    if (model_room >= 0 && need > model_room) begin
      exp_ovf = 1;
      return;
    end
    if (model_room >= 0) model_room -= need;
    a = off[AW-1:0];
    if (uds) exp_q.push_back({a, d[15:8]});
    if (lds) exp_q.push_back({a | AW'(1), d[7:0]});
  endtask

  // driver tasks
  task automatic cpu_cycle(input logic [23:0] baddr, input logic [15:0] d,
                           input bit uds, input bit lds, input bit rd, input int gap);
    @(posedge pixClock);
    #1;
    cpuAddr = baddr[23:1];
    cpuData = d;
    cpuRnW  = rd;
    nAS     = 1'b0;
    nUDS    = !uds;
    nLDS    = !lds;
    repeat (6) @(posedge pixClock);
    #1;
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; cpuRnW = 1'b1;
    repeat (gap) @(posedge pixClock);
  endtask

  task automatic bus_write(input logic [23:0] baddr, input logic [15:0] d,
                           input bit uds, input bit lds, input bit rd, input int gap);
    model_write(baddr, d, uds, lds, rd);
    cpu_cycle(baddr, d, uds, lds, rd, gap);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || wrBusy !== 1'b0) && t < 400) begin
      @(negedge pixClock);
      t++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, 32'(wrBusy), 32'd0);
  endtask

  initial begin
    int w0, t, kind;
    logic [23:0] ba;
    logic [15:0] d;
    bit u, l, r;
    nReset = 1'b0; nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; cpuRnW = 1'b1;
    cpuAddr = '0; cpuData = '0;

    repeat (3) @(posedge pixClock);
    @(negedge pixClock);
    check("rst_nwe", 32'(nvramWE), 32'd1);
    check("rst_oe", 32'(vramDataOE), 32'd0);
    check("rst_addr", 32'(vramAddr), 32'd0);
    check("rst_data", 32'(vramDataOut), 32'd0);
    check("rst_busy", 32'(wrBusy), 32'd0);
    check("rst_ovf", 32'(ovfErr), 32'd0);
    @(posedge pixClock);
    #1 nReset = 1'b1;
    repeat (4) @(posedge pixClock);

    w0 = n_writes;
    bus_write(FB_BASE, 16'hA55A, 1, 1, 0, 4);
    wait_drain("word_drain");
    check("word_count", 32'(n_writes - w0), 32'd2);

    w0 = n_writes;
    bus_write(FB_BASE + 24'h10, 16'h12CD, 1, 0, 0, 4);
    wait_drain("uds_drain");
    check("uds_count", 32'(n_writes - w0), 32'd1);

    w0 = n_writes;
    bus_write(FB_BASE - 24'd2, 16'h1111, 1, 1, 0, 4);
    bus_write(FB_BASE + 24'd8192, 16'h2222, 1, 1, 0, 4);
    repeat (30) @(posedge pixClock);
    @(negedge pixClock);
    check("oow_count", 32'(n_writes - w0), 32'd0);
    check("oow_ovf", 32'(ovfErr), 32'd0);
    check("oow_busy", 32'(wrBusy), 32'd0);

    w0 = n_writes;
    hold_val = 3'd4; hold = 1;
    bus_write(FB_BASE + 24'h100, 16'h3C96, 1, 1, 0, 20);
    @(negedge pixClock);
    check("slot4_held", 32'(n_writes - w0), 32'd0);
    check("slot4_busy", 32'(wrBusy), 32'd1);
    hold = 0;
    wait_drain("slot4_drain");
    check("slot4_count", 32'(n_writes - w0), 32'd2);

    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6)       ba = FB_BASE + 24'(2 * $urandom_range(0, 4095));
      else if (kind == 6) ba = FB_BASE;
      else if (kind == 7) ba = FB_BASE + 24'd8190;
      else if (kind == 8) ba = FB_BASE - 24'(2 * $urandom_range(1, 100));
      else                ba = FB_BASE + 24'd8192 + 24'(2 * $urandom_range(0, 100));
      d = 16'($urandom);
      u = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 7) == 0);
      bus_write(ba, d, u, l, r, $urandom_range(14, 22));
    end
    wait_drain("rand_drain");
    check("rand_ovf", 32'(ovfErr), 32'd0);

    w0 = n_writes;
    hold_val = 3'd7; hold = 1;
    model_room = DEP;
    bus_write(FB_BASE + 24'h40, 16'hDEAD, 1, 1, 0, 4);
    bus_write(FB_BASE + 24'h42, 16'hBEEF, 1, 1, 0, 4);
    bus_write(FB_BASE + 24'h44, 16'hCAFE, 1, 1, 0, 4);
    @(negedge pixClock);
    check("ovf_flag", 32'(ovfErr), 32'(exp_ovf));
    check("ovf_busy", 32'(wrBusy), 32'd1);
    check("ovf_held", 32'(n_writes - w0), 32'd0);
    hold = 0;
    model_room = -1;
    wait_drain("ovf_drain");
    check("ovf_count", 32'(n_writes - w0), 32'd4);
    check("ovf_sticky", 32'(ovfErr), 32'd1);

    bus_write(FB_BASE + 24'h20, 16'h7788, 1, 1, 0, 0);
    t = 0;
    while (nvramWE !== 1'b0 && t < 40) begin
      @(negedge pixClock);
      t++;
    end
    check("strobe_seen", 32'(t < 40), 32'd1);
    #2 nReset = 1'b0;
    #1;
    check("rst_mid_nwe", 32'(nvramWE), 32'd1);
    check("rst_mid_oe", 32'(vramDataOE), 32'd0);
    check("rst_mid_busy", 32'(wrBusy), 32'd0);
    check("rst_mid_ovf", 32'(ovfErr), 32'd0);
    exp_q.delete();
    exp_ovf = 0;
    w0 = n_writes;
    repeat (3) @(posedge pixClock);
    #1 nReset = 1'b1;
    repeat (40) @(posedge pixClock);
    @(negedge pixClock);
    check("rst_lost_bytes", 32'(n_writes - w0), 32'd0);
    check("rst_after_busy", 32'(wrBusy), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
